// File: rtl/tinker_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, redirect input and decode-side queue head.
// master = fetch unit, slave = memory/control/decode environment.
interface tinker_fetch_unit_if #(
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic [CW-1:0] queue_count;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, queue_count,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, queue_count,
    output mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch front end: one outstanding request, registered instruction queue, redirect flush.
// Request-to-inst_valid >= 2 cycles; requests stall while the queue is full, head holds under inst_ready=0.
module tinker_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_2000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  tinker_fetch_unit_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_data_q [QUEUE_DEPTH];
  logic [31:0]   r_pc_q   [QUEUE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_not_full;
  logic w_req_fire;
  logic w_push;
  logic w_pop;
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

  assign w_not_full        = (r_count < CW'(QUEUE_DEPTH));
  assign bus.mem_req_valid = !reset && (r_state == IDLE) && w_not_full && !bus.redirect_valid;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign w_req_fire        = bus.mem_req_valid && bus.mem_req_ready;

  assign w_push = (r_state == WAIT) && bus.mem_resp_valid && !bus.redirect_valid;

  assign bus.inst_valid  = (r_count != '0);
  assign bus.inst_data   = r_data_q[r_rd_ptr];
  assign bus.inst_pc     = r_pc_q[r_rd_ptr];
  assign bus.queue_count = r_count;
  assign w_pop           = bus.inst_valid && bus.inst_ready;

  // A response arriving in IDLE is a protocol error and is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req_fire) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.redirect_valid) w_state_nxt = bus.mem_resp_valid ? IDLE : DISCARD;
        else if (bus.mem_resp_valid) w_state_nxt = IDLE;
      end
      DISCARD: begin
        if (bus.mem_resp_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC & ~32'h3;
      r_req_pc   <= '0;
    end else begin
      if (bus.redirect_valid)  r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      else if (w_req_fire)     r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_req_fire)          r_req_pc   <= r_fetch_pc;
    end
  end

  // Redirect flushes the whole queue; a same-cycle pop is simply absorbed by the flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_data_q[i] <= '0;
        r_pc_q[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_data_q[r_wr_ptr] <= bus.mem_resp_data;
        r_pc_q[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit: per-cycle vector table plus hand-written corner sequences.
module tb_tinker_fetch_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  tinker_fetch_unit_if #(.QUEUE_DEPTH(4)) bus ();

  tinker_fetch_unit #(.RESET_PC(32'h0000_2000), .QUEUE_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rq_rdy;
    logic        rsp_vld;
    logic [31:0] rsp_dat;
    logic        rd_vld;
    logic [31:0] rd_pc;
    logic        in_rdy;
    logic        e_req_vld;
    logic [31:0] e_addr;
    logic        e_inst_vld;
    logic [31:0] e_data;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic rq, logic rv, logic [31:0] rd, logic dv, logic [31:0] dp,
                              logic ir, logic ev, logic [31:0] ea, logic eiv, logic [31:0] ed,
                              logic [31:0] ep, logic [2:0] ec);
    vec_t v;
    v.rq_rdy = rq; v.rsp_vld = rv; v.rsp_dat = rd; v.rd_vld = dv; v.rd_pc = dp; v.in_rdy = ir;
    v.e_req_vld = ev; v.e_addr = ea; v.e_inst_vld = eiv; v.e_data = ed; v.e_pc = ep; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rq, input logic rv, input logic [31:0] rd,
                       input logic dv, input logic [31:0] dp, input logic ir);
    bus.mem_req_ready  = rq;
    bus.mem_resp_valid = rv;
    bus.mem_resp_data  = rd;
    bus.redirect_valid = dv;
    bus.redirect_pc    = dp;
    bus.inst_ready     = ir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    //              rq rv data          dv pc          ir | ev addr         iv data          pc          cnt
    vecs[0]  = mk(1, 0, 32'h0,        0, 32'h0,     1,  1, 32'h2000, 0, 32'h0,        32'h0,    0);
    vecs[1]  = mk(1, 1, 32'hAAAA0001, 0, 32'h0,     1,  0, 32'h2004, 0, 32'h0,        32'h0,    0);
    vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,     1,  1, 32'h2004, 1, 32'hAAAA0001, 32'h2000, 1);
    vecs[3]  = mk(1, 1, 32'hAAAA0002, 0, 32'h0,     1,  0, 32'h2008, 0, 32'h0,        32'h0,    0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,     1,  1, 32'h2008, 1, 32'hAAAA0002, 32'h2004, 1);
    vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,     1,  1, 32'h2008, 0, 32'h0,        32'h0,    0);
    vecs[6]  = mk(0, 0, 32'h0,        1, 32'h3001,  1,  0, 32'h200C, 0, 32'h0,        32'h0,    0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,     1,  0, 32'h3000, 0, 32'h0,        32'h0,    0);
    vecs[8]  = mk(0, 1, 32'hDEAD0008, 0, 32'h0,     1,  0, 32'h3000, 0, 32'h0,        32'h0,    0);
    vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,     1,  1, 32'h3000, 0, 32'h0,        32'h0,    0);
    vecs[10] = mk(0, 1, 32'hBBBB3000, 0, 32'h0,     0,  0, 32'h3004, 0, 32'h0,        32'h0,    0);
    vecs[11] = mk(1, 0, 32'h0,        0, 32'h0,     0,  1, 32'h3004, 1, 32'hBBBB3000, 32'h3000, 1);
    vecs[12] = mk(0, 1, 32'hCCCC3004, 1, 32'h4000,  1,  0, 32'h3008, 1, 32'hBBBB3000, 32'h3000, 1);
    vecs[13] = mk(1, 0, 32'h0,        0, 32'h0,     1,  1, 32'h4000, 0, 32'h0,        32'h0,    0);
    vecs[14] = mk(0, 1, 32'hDDDD4000, 0, 32'h0,     1,  0, 32'h4004, 0, 32'h0,        32'h0,    0);
    vecs[15] = mk(0, 0, 32'h0,        0, 32'h0,     1,  1, 32'h4004, 1, 32'hDDDD4000, 32'h4000, 1);
    vecs[16] = mk(0, 1, 32'hEEEE0000, 0, 32'h0,     1,  1, 32'h4004, 0, 32'h0,        32'h0,    0);
    vecs[17] = mk(0, 0, 32'h0,        0, 32'h0,     1,  1, 32'h4004, 0, 32'h0,        32'h0,    0);
    vecs[18] = mk(1, 0, 32'h0,        1, 32'h5003,  1,  0, 32'h4004, 0, 32'h0,        32'h0,    0);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,     1,  1, 32'h5000, 0, 32'h0,        32'h0,    0);

    #2;
    chk("rst_req_vld",  32'(bus.mem_req_valid), 32'h0);
    chk("rst_addr",     bus.mem_req_addr,        32'h2000);
    chk("rst_inst_vld", 32'(bus.inst_valid),     32'h0);
    chk("rst_data",     bus.inst_data,           32'h0);
    chk("rst_pc",       bus.inst_pc,             32'h0);
    chk("rst_cnt",      32'(bus.queue_count),    32'h0);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rq_rdy, vecs[i].rsp_vld, vecs[i].rsp_dat, vecs[i].rd_vld, vecs[i].rd_pc, vecs[i].in_rdy);
      #1;
      chk($sformatf("vec%0d_req_vld", i),  32'(bus.mem_req_valid), 32'(vecs[i].e_req_vld));
      chk($sformatf("vec%0d_addr", i),     bus.mem_req_addr,        vecs[i].e_addr);
      chk($sformatf("vec%0d_inst_vld", i), 32'(bus.inst_valid),     32'(vecs[i].e_inst_vld));
      chk($sformatf("vec%0d_cnt", i),      32'(bus.queue_count),    32'(vecs[i].e_cnt));
      if (vecs[i].e_inst_vld) begin
        chk($sformatf("vec%0d_data", i), bus.inst_data, vecs[i].e_data);
        chk($sformatf("vec%0d_pc", i),   bus.inst_pc,   vecs[i].e_pc);
      end
      @(negedge clk);
    end

    // Backpressure: fill the queue with decode stalled.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("bp%0d_req_vld", i), 32'(bus.mem_req_valid), 32'h1);
      chk($sformatf("bp%0d_addr", i),    bus.mem_req_addr,        32'h2000 + 32'(4 * i));
      chk($sformatf("bp%0d_cnt", i),     32'(bus.queue_count),    32'(i));
      @(negedge clk);
      drive(0, 1, 32'h1111_0000 + 32'(i), 0, 0, 0);
      @(negedge clk);
    end
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("bp_full_cnt",     32'(bus.queue_count),    32'h4);
    chk("bp_full_req_vld", 32'(bus.mem_req_valid), 32'h0);
    chk("bp_full_data",    bus.inst_data,           32'h1111_0000);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1);
    #1;
    chk("bp_pop_req_vld",  32'(bus.mem_req_valid), 32'h0);
    chk("bp_pop_pc",       bus.inst_pc,             32'h2000);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("bp_after_cnt",     32'(bus.queue_count),    32'h3);
    chk("bp_after_req_vld", 32'(bus.mem_req_valid), 32'h1);
    chk("bp_after_addr",    bus.mem_req_addr,        32'h2010);
    @(negedge clk);

    // Stall hold: head must not move while a response lands behind it.
    for (int k = 0; k < 5; k++) begin
      drive(0, (k == 0), 32'h1111_0004, 0, 0, 0);
      #1;
      chk($sformatf("hold%0d_vld", k),  32'(bus.inst_valid), 32'h1);
      chk($sformatf("hold%0d_data", k), bus.inst_data,       32'h1111_0001);
      chk($sformatf("hold%0d_pc", k),   bus.inst_pc,         32'h2004);
      @(negedge clk);
    end
    chk("hold_cnt", 32'(bus.queue_count), 32'h4);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      #1;
      chk($sformatf("drain%0d_data", k), bus.inst_data, 32'h1111_0001 + 32'(k));
      chk($sformatf("drain%0d_pc", k),   bus.inst_pc,   32'h2004 + 32'(4 * k));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("drain_empty_vld", 32'(bus.inst_valid),  32'h0);
    chk("drain_empty_cnt", 32'(bus.queue_count), 32'h0);
    @(negedge clk);

    // Asynchronous reset between edges while a request is outstanding.
    drive(1, 0, 0, 0, 0, 0);
    #1 chk("ar_addr0", bus.mem_req_addr, 32'h2014);
    @(negedge clk);
    drive(0, 1, 32'h2222_2014, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    #1 chk("ar_addr1", bus.mem_req_addr, 32'h2018);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_pre_cnt",  32'(bus.queue_count), 32'h1);
    chk("ar_pre_addr", bus.mem_req_addr,     32'h201C);
    #2 reset = 1'b1;
    #1;
    chk("ar_req_vld",  32'(bus.mem_req_valid), 32'h0);
    chk("ar_addr",     bus.mem_req_addr,        32'h2000);
    chk("ar_inst_vld", 32'(bus.inst_valid),     32'h0);
    chk("ar_cnt",      32'(bus.queue_count),    32'h0);
    chk("ar_data",     bus.inst_data,           32'h0);
    chk("ar_pc",       bus.inst_pc,             32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("ar_post_req_vld", 32'(bus.mem_req_valid), 32'h1);
    chk("ar_post_addr",    bus.mem_req_addr,        32'h2000);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tinker_fetch_unit.md
Name: tinker_fetch_unit

Overview:
Instruction fetch front end for the Tinker core. It issues 32-bit instruction fetch requests to a variable-latency instruction memory port and buffers the returned words with their PCs in a small FIFO. It presents them to the decode/control stage over a valid/ready handshake. It also accepts PC redirects (taken branches, call, return) from control, which flush queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_2000, fetch address loaded on reset.
QUEUE_DEPTH, 4, number of instruction queue entries; must be a power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts the request this cycle.
mem_req_addr  out  32  byte address of the instruction word; bits [1:0] always 0.
mem_resp_valid  in  1  returned instruction word valid.
mem_resp_data  in  32  instruction word, already little-endian assembled.
redirect_valid  in  1  control redirects fetch this cycle.
redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0.
inst_valid  out  1  head of the queue is valid.
inst_ready  in  1  decode consumes the head this cycle.
inst_data  out  32  instruction at the queue head.
inst_pc  out  32  PC of inst_data.
queue_count  out  clog2(QUEUE_DEPTH)+1  current queue occupancy (debug/perf).

Behaviour:
- Reset (asynchronous) values:
  - fetch_pc = RESET_PC; state = IDLE; queue empty.
  - mem_req_valid = 0, inst_valid = 0, queue_count = 0.
  - inst_data and inst_pc = 0.
- Single outstanding request maximum. FSM states:
  - IDLE: no request in flight.
  - WAIT: request accepted, awaiting response.
  - DISCARD: request in flight but invalidated by a redirect.
- mem_req_valid = (state == IDLE) && (queue_count < QUEUE_DEPTH) && !redirect_valid, driven combinationally from registered state plus redirect_valid.
- mem_req_addr = fetch_pc.
- Request handshake (mem_req_valid && mem_req_ready):
  - req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (32-bit wrap, no overflow detection).
  - IDLE -> WAIT.
- A request that is not accepted may be dropped or retargeted freely. Memory samples only on the handshake.
- WAIT with mem_resp_valid and no redirect: push {req_pc, mem_resp_data}; WAIT -> IDLE.
  - A new request may issue in the following cycle.
  - Throughput is therefore at most one instruction per 2 cycles plus memory latency.
- Push lands in a registered FIFO, with no bypass. An instruction is visible on inst_valid the cycle after its response. The minimum request-to-inst_valid latency is 2 cycles (response in the cycle after the request).
- Queue space is checked at issue time, so a push never finds the queue full.
- Pop: inst_valid && inst_ready advances the read pointer. Push and pop may occur in the same cycle; count is unchanged.
- inst_data and inst_pc must hold stable while inst_valid = 1 and inst_ready = 0.
- Redirect (redirect_valid = 1), which has priority over all other events in that cycle:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; queue cleared (count 0, pointers reset). Any simultaneous push is dropped.
  - A simultaneous pop is allowed and counts as consumed; the queue is empty next cycle regardless.
  - IDLE stays IDLE; no request issues this cycle because mem_req_valid is forced low.
  - WAIT without mem_resp_valid goes to DISCARD.
  - WAIT with mem_resp_valid drops the response and goes to IDLE.
  - DISCARD stays DISCARD, or goes to IDLE if mem_resp_valid is high that cycle (response dropped).
- DISCARD with mem_resp_valid (no redirect): response dropped; go to IDLE.
- mem_resp_valid while in IDLE is a protocol error: ignore it, with no state change.
- Reset asserted mid-operation, including in WAIT or DISCARD, returns to reset values immediately. The memory must not return a response for a pre-reset request.

Test Plan:
- Reset then zero-wait memory: the first request is to 0x2000.
  - Responses 0xAAAA0001, 0xAAAA0002 with inst_ready = 1 appear on inst_data with inst_pc 0x2000 and 0x2004, in order.
- Backpressure with QUEUE_DEPTH = 4 and inst_ready = 0: after 4 pushes, queue_count = 4 and mem_req_valid stays 0.
  - Raise inst_ready for 1 cycle: count drops to 3 and a request to 0x2010 issues the next cycle.
- Redirect in WAIT: request to 0x2008 accepted, then redirect_valid with redirect_pc = 0x3001 before the response.
  - The 3-cycle-late response is dropped and the queue stays empty.
  - The next request address is 0x3000, and the instruction later appears with inst_pc = 0x3000.
- Redirect in the same cycle as mem_resp_valid and a pop: the response is not enqueued and inst_valid = 0 next cycle.
  - The next request goes to the redirect target, not the old fetch_pc + 4.
- Stall hold: inst_valid = 1, inst_ready = 0 for 5 cycles with responses arriving.
  - inst_data and inst_pc are unchanged throughout; order is preserved once released.
- Asynchronous reset asserted mid-WAIT between clock edges: outputs return to reset values before the next edge.
  - After release, the first request is again 0x2000.
